// File: rtl/dig_write_arbiter.sv
// Round-robin arbiter sharing the 7-segment display between two write requesters.
// Each write is a single-cycle strobe, followed by a fixed hold time before the next grant.
module dig_write_arbiter #(
    parameter logic [31:0] DIG_ADDR    = 32'hFFFF_F000,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        clk_from_bg,
    input  logic        rst_from_bg,
    input  logic        req0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    input  logic        req1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic        busy,
    output logic [31:0] cur_val,
    output logic [31:0] addr_2_dig,
    output logic        we_2_dig,
    output logic [31:0] wdata_2_dig
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             lastGrant_q, lastGrant_d;
    logic             winner_q, winner_d;
    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      curVal_q, curVal_d;
    logic             pick;

    // lastGrant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_from_bg or negedge rst_from_bg) begin
        if (!rst_from_bg) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            winner_q    <= 1'b0;
            holdCnt_q   <= '0;
            wdata_q     <= '0;
            curVal_q    <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            winner_q    <= winner_d;
            holdCnt_q   <= holdCnt_d;
            wdata_q     <= wdata_d;
            curVal_q    <= curVal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        winner_d    = winner_q;
        holdCnt_d   = holdCnt_q;
        wdata_d     = wdata_q;
        curVal_d    = curVal_q;
        // Requester 1 wins when alone, or on a tie when requester 0 was served last.
        pick        = req1 & (~req0 | ~lastGrant_q);

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winner_d    = pick;
                    lastGrant_d = pick;
                    wdata_d     = pick ? wdata1 : wdata0;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                curVal_d  = wdata_q;
                holdCnt_d = HOLD_LOAD;
                state_d   = HOLD;
            end
            HOLD: begin
                if (holdCnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    holdCnt_d = holdCnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign we_2_dig    = (state_q == WRITE);
    assign addr_2_dig  = we_2_dig ? DIG_ADDR : 32'h0;
    assign ack0        = we_2_dig & ~winner_q;
    assign ack1        = we_2_dig & winner_q;
    assign busy        = (state_q != IDLE);
    assign cur_val     = curVal_q;
    assign wdata_2_dig = wdata_q;

endmodule

// File: tb/tb_dig_write_arbiter.sv
// Self-checking bench for dig_write_arbiter: a scoreboard of expected writes
// is filled by each scenario and drained by a monitor watching the write strobe.
module tb_dig_write_arbiter;

   localparam logic [31:0] DIG_ADDR = 32'hFFFF_F000;
   localparam int          HOLD     = 16;

   typedef struct packed {
      logic        who;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req0;
   logic [31:0] wdata0;
   logic        ack0;
   logic        req1;
   logic [31:0] wdata1;
   logic        ack1;
   logic        busy;
   logic [31:0] cur_val;
   logic [31:0] addr_2_dig;
   logic        we_2_dig;
   logic [31:0] wdata_2_dig;

   int   compared;
   int   mismatched;
   exp_t expQ[$];
   exp_t monExp;

   dig_write_arbiter #(
      .DIG_ADDR    (DIG_ADDR),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk_from_bg (clk),
      .rst_from_bg (rst_n),
      .req0        (req0),
      .wdata0      (wdata0),
      .ack0        (ack0),
      .req1        (req1),
      .wdata1      (wdata1),
      .ack1        (ack1),
      .busy        (busy),
      .cur_val     (cur_val),
      .addr_2_dig  (addr_2_dig),
      .we_2_dig    (we_2_dig),
      .wdata_2_dig (wdata_2_dig)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every write strobe must match the oldest expected write, including which ack fires.
   always @(negedge clk) begin
      if (rst_n && we_2_dig) begin
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_write: got wdata=%h ack0=%b ack1=%b, required no write",
                     wdata_2_dig, ack0, ack1);
         end else begin
            monExp = expQ.pop_front();
            if ({ack1, ack0, addr_2_dig, wdata_2_dig} !== {monExp.who, ~monExp.who, DIG_ADDR, monExp.data}) begin
               mismatched++;
               $display("[TB] FAIL write_scoreboard: got ack1=%b ack0=%b addr=%h wdata=%h, required ack1=%b ack0=%b addr=%h wdata=%h",
                        ack1, ack0, addr_2_dig, wdata_2_dig, monExp.who, ~monExp.who, DIG_ADDR, monExp.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Steps until the chosen ack is seen or the budget runs out; caller judges the result.
   task automatic waitAck(input bit which, input int budget, output bit found, output int waited);
      found  = 1'b0;
      waited = 0;
      while (!found && waited < budget) begin
         tick();
         waited++;
         if (which ? ack1 : ack0) found = 1'b1;
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      req0   = 1'b0;
      req1   = 1'b0;
      wdata0 = 32'h0;
      wdata1 = 32'h0;
      repeat (3) tick();
      compared++;
      if ({busy, we_2_dig, ack0, ack1} !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_ctrl: got busy/we/ack0/ack1=%b, required 0000", {busy, we_2_dig, ack0, ack1});
      end
      compared++;
      if (cur_val !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_cur_val: got %h, required 00000000", cur_val);
      end
      compared++;
      if ({addr_2_dig, wdata_2_dig} !== 64'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_bus: got addr=%h wdata=%h, required 0/0", addr_2_dig, wdata_2_dig);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int busyCnt;
      req0   = 1'b1;
      wdata0 = 32'h1234_6789;
      expQ.push_back('{who: 1'b0, data: 32'h1234_6789});
      tick();
      compared++;
      if ({we_2_dig, ack0, busy} !== 3'b111) begin
         mismatched++;
         $display("[TB] FAIL single_latency: got we/ack0/busy=%b, required 111", {we_2_dig, ack0, busy});
      end
      req0    = 1'b0;
      wdata0  = 32'h0;
      busyCnt = 0;
      for (int i = 0; i < HOLD; i++) begin
         tick();
         if (busy && !we_2_dig) busyCnt++;
         if (i == 0) begin
            compared++;
            if (cur_val !== 32'h1234_6789) begin
               mismatched++;
               $display("[TB] FAIL single_cur_val: got %h, required 12346789", cur_val);
            end
         end
      end
      compared++;
      if (busyCnt !== HOLD) begin
         mismatched++;
         $display("[TB] FAIL single_hold_len: got %0d busy hold cycles, required %0d", busyCnt, HOLD);
      end
      tick();
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL single_hold_end: got busy=%b, required 0", busy);
      end
   endtask

   task automatic test_tie();
      bit found;
      int waited;
      rst_n = 1'b0;
      tick();
      rst_n  = 1'b1;
      tick();
      req0   = 1'b1;
      wdata0 = 32'h1111_1111;
      req1   = 1'b1;
      wdata1 = 32'h2222_2222;
      expQ.push_back('{who: 1'b0, data: 32'h1111_1111});
      expQ.push_back('{who: 1'b1, data: 32'h2222_2222});
      waitAck(1'b0, 5, found, waited);
      compared++;
      if (!found || waited != 1) begin
         mismatched++;
         $display("[TB] FAIL tie_first_grant: got found=%b after %0d cycles, required ack0 after 1", found, waited);
      end
      req0 = 1'b0;
      waitAck(1'b1, 40, found, waited);
      compared++;
      if (!found || waited != HOLD + 2) begin
         mismatched++;
         $display("[TB] FAIL tie_second_grant: got found=%b gap=%0d, required ack1 gap=%0d", found, waited, HOLD + 2);
      end
      req1 = 1'b0;
      waitIdle();
   endtask

   task automatic test_fairness();
      int  waited;
      bit  order[6];
      int  gaps[6];
      bit  seen[6];
      req0   = 1'b1;
      wdata0 = 32'hA000_0000;
      req1   = 1'b1;
      wdata1 = 32'hB000_0001;
      for (int k = 0; k < 6; k++) begin
         expQ.push_back('{who: k[0], data: k[0] ? 32'hB000_0001 : 32'hA000_0000});
      end
      for (int k = 0; k < 6; k++) begin
         waited  = 0;
         seen[k] = 1'b0;
         while (!seen[k] && waited < 25) begin
            tick();
            waited++;
            if (we_2_dig) seen[k] = 1'b1;
         end
         order[k] = ack1;
         gaps[k]  = waited;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         compared++;
         if (!seen[k] || order[k] !== k[0] || gaps[k] != ((k == 0) ? 1 : HOLD + 2)) begin
            mismatched++;
            $display("[TB] FAIL fairness_%0d: got seen=%b requester=%0d gap=%0d, required requester=%0d gap=%0d",
                     k, seen[k], order[k], gaps[k], k[0], (k == 0) ? 1 : HOLD + 2);
         end
      end
      waitIdle();
   endtask

   task automatic test_hold_ignore();
      bit found;
      int waited;
      int writes;
      req0   = 1'b1;
      wdata0 = 32'h5555_0000;
      expQ.push_back('{who: 1'b0, data: 32'h5555_0000});
      waitAck(1'b0, 5, found, waited);
      compared++;
      if (!found) begin
         mismatched++;
         $display("[TB] FAIL ignore_setup: got no ack0, required ack0");
      end
      req0 = 1'b0;
      repeat (2) tick();
      req1   = 1'b1;
      wdata1 = 32'h3333_0001;
      repeat (2) tick();
      wdata1 = 32'h3333_0002;
      repeat (2) tick();
      wdata1 = 32'h3333_0003;
      repeat (3) tick();
      req1 = 1'b0;
      writes = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (we_2_dig) writes++;
      end
      compared++;
      if (writes != 0) begin
         mismatched++;
         $display("[TB] FAIL ignore_no_write: got %0d writes, required 0", writes);
      end
      compared++;
      if ({busy, cur_val} !== {1'b0, 32'h5555_0000}) begin
         mismatched++;
         $display("[TB] FAIL ignore_cur_val: got busy=%b cur_val=%h, required busy=0 cur_val=55550000", busy, cur_val);
      end
   endtask

   task automatic test_reset_mid_hold();
      bit found;
      int waited;
      req0   = 1'b1;
      wdata0 = 32'h7777_0000;
      expQ.push_back('{who: 1'b0, data: 32'h7777_0000});
      waitAck(1'b0, 5, found, waited);
      req0 = 1'b0;
      repeat (5) tick();
      compared++;
      if ({found, busy, cur_val} !== {1'b1, 1'b1, 32'h7777_0000}) begin
         mismatched++;
         $display("[TB] FAIL midrst_before: got ack=%b busy=%b cur_val=%h, required 1/1/77770000", found, busy, cur_val);
      end
      #2;
      rst_n = 1'b0;
      #1;
      compared++;
      if ({busy, cur_val, wdata_2_dig} !== {1'b0, 32'h0, 32'h0}) begin
         mismatched++;
         $display("[TB] FAIL midrst_async: got busy=%b cur_val=%h wdata=%h, required 0/0/0", busy, cur_val, wdata_2_dig);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      req1   = 1'b1;
      wdata1 = 32'hDEAD_BEEF;
      expQ.push_back('{who: 1'b1, data: 32'hDEAD_BEEF});
      waitAck(1'b1, 5, found, waited);
      compared++;
      if (!found || waited != 1) begin
         mismatched++;
         $display("[TB] FAIL midrst_new_write: got found=%b after %0d cycles, required ack1 after 1", found, waited);
      end
      req1 = 1'b0;
      tick();
      compared++;
      if (cur_val !== 32'hDEAD_BEEF) begin
         mismatched++;
         $display("[TB] FAIL midrst_cur_val: got %h, required deadbeef", cur_val);
      end
      waitIdle();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_single();
      test_tie();
      test_fairness();
      test_hold_ignore();
      test_reset_mid_hold();
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d writes still expected, required 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
